// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit SS.CC seven-segment scanner.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; digit enables are one-cold.
package fnd_pkg;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [3:0] COM_SEL [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  localparam int unsigned MSEC_MAX  = 99;
  localparam int unsigned SEC_MAX   = 59;
  localparam int unsigned MSEC_HALF = 50;

  typedef enum logic [1:0] {
    DigMsecOnes = 2'd0,
    DigMsecTens = 2'd1,
    DigSecOnes  = 2'd2,
    DigSecTens  = 2'd3
  } digit_e;

endpackage

// File: rtl/fnd_bcd_to_seg.sv
// BCD digit (or dash) to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal codes blank the digit.
module fnd_bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = SEG_BLANK;
    if (dash) begin
      code = SEG_DASH;
    end else if (bcd <= 4'd9) begin
      code = SEG_DIGIT[bcd];
    end
    seg = code[6:0];
  end

endmodule

// File: rtl/fnd_time_scanner.sv
// Scans binary centiseconds/seconds onto a 4-digit common-anode display as SS.CC.
// Define FND_DP_BLINK_EN to light the decimal point only during the first half second.
module fnd_time_scanner
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000,
  parameter int unsigned MSEC_W   = 7,
  parameter int unsigned SEC_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MSEC_W-1:0] i_msec,
  input  logic [SEC_W-1:0]  i_sec,
  output logic [7:0]        fnd_data,
  output logic [3:0]        fnd_com,
  output logic              o_frame_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CntW-1:0]   scan_cnt_q;
  logic              scan_tick;
  digit_e            idx_q, idx_next;
  logic [MSEC_W-1:0] msec_q, msec_cur;
  logic [SEC_W-1:0]  sec_q, sec_cur;
  logic              msec_oor, sec_oor;
  logic [3:0]        bcd;
  logic              dash;
  logic              dp;
  logic [6:0]        seg;
  logic [7:0]        data_q;
  logic [3:0]        com_q;
  logic              frame_q;

  assign scan_tick = (scan_cnt_q == CntW'(SCAN_DIV - 1));
  assign idx_next  = digit_e'(idx_q + 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_q <= '0;
      idx_q      <= DigSecTens;
    end else if (scan_tick) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_next;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msec_q <= '0;
      sec_q  <= '0;
    end else if (scan_tick && (idx_next == DigMsecOnes)) begin
      msec_q <= i_msec;
      sec_q  <= i_sec;
    end
  end

  // The digit being registered on a frame-wrap tick must already see the new samples.
  assign msec_cur = (idx_next == DigMsecOnes) ? i_msec : msec_q;
  assign sec_cur  = (idx_next == DigMsecOnes) ? i_sec  : sec_q;

  assign msec_oor = (msec_cur > MSEC_W'(MSEC_MAX));
  assign sec_oor  = (sec_cur  > SEC_W'(SEC_MAX));

  always_comb begin
    bcd  = 4'd0;
    dash = 1'b0;
    dp   = 1'b1;
    unique case (idx_next)
      DigMsecOnes: begin
        bcd  = 4'(msec_cur % MSEC_W'(10));
        dash = msec_oor;
      end
      DigMsecTens: begin
        bcd  = 4'(msec_cur / MSEC_W'(10));
        dash = msec_oor;
      end
      DigSecOnes: begin
        bcd  = 4'(sec_cur % SEC_W'(10));
        dash = sec_oor;
`ifdef FND_DP_BLINK_EN
        dp   = (msec_cur < MSEC_W'(MSEC_HALF)) ? 1'b0 : 1'b1;
`else
        dp   = 1'b0;
`endif
      end
      DigSecTens: begin
        bcd  = 4'(sec_cur / SEC_W'(10));
        dash = sec_oor;
      end
      default: ;
    endcase
  end

  fnd_bcd_to_seg u_bcd_to_seg (
    .bcd  (bcd),
    .dash (dash),
    .seg  (seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      com_q   <= 4'b1111;
      data_q  <= SEG_BLANK;
      frame_q <= 1'b0;
    end else begin
      frame_q <= scan_tick && (idx_next == DigMsecOnes);
      if (scan_tick) begin
        com_q  <= COM_SEL[idx_next];
        data_q <= {dp, seg};
      end
    end
  end

  assign fnd_com      = com_q;
  assign fnd_data     = data_q;
  assign o_frame_tick = frame_q;

endmodule
